// File: rtl/scumv_asc_pkg.sv
// scumv_asc_pkg
//   Shared constants for the SCuM-V ASC scan-chain driver: FSM state
//   encodings, the default packet size and the acknowledge byte returned
//   after every completed scan.
package scumv_asc_pkg;

    localparam int          STATE_W          = 3;

    localparam logic [2:0]  COLLECT          = 3'd0;
    localparam logic [2:0]  SHIFT_LO         = 3'd1;
    localparam logic [2:0]  SHIFT_HI         = 3'd2;
    localparam logic [2:0]  UPDATE           = 3'd3;
    localparam logic [2:0]  RESPOND          = 3'd4;

    localparam int          ASC_PACKET_BYTES = 22;
    localparam logic [7:0]  ASC_ACK_BYTE     = 8'h01;

endpackage

// File: rtl/scumv_asc_scan_driver_clk_div.sv
// scumv_scan_clk_div
//   Half-period counter for the scan clock. Counts 0..DIV-1 and raises
//   `tick` combinationally on the terminal count, wrapping to 0 afterwards.
//   Ports:
//     clk   in  system clock
//     reset in  synchronous active-high reset
//     clear in  synchronous clear (driven on every FSM state change / idle)
//     tick  out high while the counter sits at DIV-1
module scumv_scan_clk_div #(
    parameter int DIV = 50
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int             CNT_W = $clog2(DIV + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_r;

    assign tick = (cnt_r == LAST);

    // Half-period counter: cleared on state change, wraps after terminal count.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (clear || tick) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

endmodule

// File: rtl/scumv_asc_scan_driver.sv
// scumv_asc_scan_driver
//   Collects PACKET_BYTES bytes from the ASC stream into a shift register,
//   shifts them LSB-first into the SCuM-V scan chain on a divided scan clock,
//   pulses scan_update for two half-periods and returns ACK_BYTE.
//   Ports:
//     clk, reset                       clock, synchronous active-high reset
//     asc_data_valid/ready/in          byte stream in (valid/ready handshake)
//     asc_response_valid/ready/data    acknowledge byte out
//     scan_clk, scan_in, scan_update   registered scan chain outputs
//     busy                             high outside COLLECT
//     debug_state                      current FSM state encoding
module scumv_asc_scan_driver
    import scumv_asc_pkg::*;
#(
    parameter int         PACKET_BYTES = ASC_PACKET_BYTES,
    parameter int         SCAN_CLK_DIV = 50,
    parameter logic [7:0] ACK_BYTE     = ASC_ACK_BYTE
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         asc_data_valid,
    output logic         asc_data_ready,
    input  logic [7:0]   asc_data_in,
    output logic         asc_response_valid,
    input  logic         asc_response_ready,
    output logic [7:0]   asc_response_data,
    output logic         scan_clk,
    output logic         scan_in,
    output logic         scan_update,
    output logic         busy,
    output logic [2:0]   debug_state
);

    localparam int CHAIN_BITS = 8 * PACKET_BYTES;
    localparam int BYTE_W     = (PACKET_BYTES > 1) ? $clog2(PACKET_BYTES) : 1;
    localparam int BIT_W      = $clog2(CHAIN_BITS);
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(PACKET_BYTES - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(CHAIN_BITS - 1);

    logic [STATE_W-1:0]    state_r;
    logic [STATE_W-1:0]    next_state_s;
    logic [BYTE_W-1:0]     byte_cnt_r;
    logic [BIT_W-1:0]      bit_cnt_r;
    logic [CHAIN_BITS-1:0] shreg_r;
    logic [CHAIN_BITS-1:0] shreg_next_s;
    logic                  upd_half_r;
    logic                  byte_fire_s;
    logic                  tick_s;
    logic                  div_clear_s;

    logic                  ready_s;
    logic                  busy_s;
    logic                  sclk_s;
    logic                  sin_s;
    logic                  supd_s;
    logic                  rvalid_s;
    logic [7:0]            rdata_s;

    assign byte_fire_s = asc_data_valid && (state_r == COLLECT);
    assign debug_state = state_r;
    // Divider idles at 0 outside the timed states and restarts on each entry.
    assign div_clear_s = (next_state_s != state_r) || (state_r == COLLECT)
                         || (state_r == RESPOND);

    scumv_scan_clk_div #(
        .DIV (SCAN_CLK_DIV)
    ) u_clk_div (
        .clk   (clk),
        .reset (reset),
        .clear (div_clear_s),
        .tick  (tick_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= COLLECT;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            COLLECT: begin
                if (byte_fire_s && (byte_cnt_r == LAST_BYTE)) next_state_s = SHIFT_LO;
                else                                          next_state_s = COLLECT;
            end
            SHIFT_LO: begin
                if (tick_s) next_state_s = SHIFT_HI;
                else        next_state_s = SHIFT_LO;
            end
            SHIFT_HI: begin
                if (tick_s) next_state_s = (bit_cnt_r == LAST_BIT) ? UPDATE : SHIFT_LO;
                else        next_state_s = SHIFT_HI;
            end
            UPDATE: begin
                // Two divider periods: first tick arms upd_half_r, second exits.
                if (tick_s && upd_half_r) next_state_s = RESPOND;
                else                      next_state_s = UPDATE;
            end
            RESPOND: begin
                if (asc_response_ready) next_state_s = COLLECT;
                else                    next_state_s = RESPOND;
            end
            default: next_state_s = COLLECT;
        endcase
    end

    // Shift register next value: byte capture in COLLECT, shift on SHIFT_HI exit.
    always_comb begin
        shreg_next_s = shreg_r;
        if (byte_fire_s) begin
            for (int k = 0; k < PACKET_BYTES; k++) begin
                if (byte_cnt_r == BYTE_W'(k)) shreg_next_s[8*k +: 8] = asc_data_in;
                else                          shreg_next_s[8*k +: 8] = shreg_r[8*k +: 8];
            end
        end else if ((state_r == SHIFT_HI) && tick_s) begin
            shreg_next_s = {1'b0, shreg_r[CHAIN_BITS-1:1]};
        end else begin
            shreg_next_s = shreg_r;
        end
    end

    // Output decode from the next state so the flopped outputs line up with it.
    always_comb begin
        ready_s  = (next_state_s == COLLECT);
        busy_s   = (next_state_s != COLLECT);
        sclk_s   = (next_state_s == SHIFT_HI);
        supd_s   = (next_state_s == UPDATE);
        rvalid_s = (next_state_s == RESPOND);
        if ((next_state_s == SHIFT_LO) || (next_state_s == SHIFT_HI)) sin_s = shreg_next_s[0];
        else                                                          sin_s = 1'b0;
        if (rvalid_s) rdata_s = ACK_BYTE;
        else          rdata_s = 8'h00;
    end

    // Datapath counters, shift register and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt_r         <= '0;
            bit_cnt_r          <= '0;
            upd_half_r         <= 1'b0;
            shreg_r            <= '0;
            asc_data_ready     <= 1'b1;
            busy               <= 1'b0;
            scan_clk           <= 1'b0;
            scan_in            <= 1'b0;
            scan_update        <= 1'b0;
            asc_response_valid <= 1'b0;
            asc_response_data  <= 8'h00;
        end else begin
            shreg_r            <= shreg_next_s;
            asc_data_ready     <= ready_s;
            busy               <= busy_s;
            scan_clk           <= sclk_s;
            scan_in            <= sin_s;
            scan_update        <= supd_s;
            asc_response_valid <= rvalid_s;
            asc_response_data  <= rdata_s;

            if (byte_fire_s) begin
                byte_cnt_r <= (byte_cnt_r == LAST_BYTE) ? '0 : byte_cnt_r + BYTE_W'(1);
            end else begin
                byte_cnt_r <= byte_cnt_r;
            end

            if ((state_r == SHIFT_HI) && tick_s) begin
                bit_cnt_r <= (bit_cnt_r == LAST_BIT) ? '0 : bit_cnt_r + BIT_W'(1);
            end else begin
                bit_cnt_r <= bit_cnt_r;
            end

            if ((state_r == UPDATE) && tick_s) upd_half_r <= ~upd_half_r;
            else if (state_r != UPDATE)        upd_half_r <= 1'b0;
            else                               upd_half_r <= upd_half_r;
        end
    end

endmodule

// File: tb/tb_scumv_asc_scan_driver.sv
// Self-checking bench for scumv_asc_scan_driver. Two instances (scan clock
// divider 2 and 1) share the stimulus; `sel` picks which one is observed.
module tb_scumv_asc_scan_driver;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       asc_data_valid = 1'b0;
    logic [7:0] asc_data_in = 8'h00;
    logic       asc_response_ready = 1'b1;
    logic       sel = 1'b0;

    always #5 clk = ~clk;

    logic       d2_ready, d2_rv, d2_sclk, d2_sin, d2_upd, d2_busy;
    logic [7:0] d2_rdata;
    logic [2:0] d2_state;
    logic       d1_ready, d1_rv, d1_sclk, d1_sin, d1_upd, d1_busy;
    logic [7:0] d1_rdata;
    logic [2:0] d1_state;

    scumv_asc_scan_driver #(.PACKET_BYTES(22), .SCAN_CLK_DIV(2), .ACK_BYTE(8'h01)) dut_d2 (
        .clk(clk), .reset(reset),
        .asc_data_valid(asc_data_valid), .asc_data_ready(d2_ready), .asc_data_in(asc_data_in),
        .asc_response_valid(d2_rv), .asc_response_ready(asc_response_ready),
        .asc_response_data(d2_rdata), .scan_clk(d2_sclk), .scan_in(d2_sin),
        .scan_update(d2_upd), .busy(d2_busy), .debug_state(d2_state)
    );

    scumv_asc_scan_driver #(.PACKET_BYTES(22), .SCAN_CLK_DIV(1), .ACK_BYTE(8'h01)) dut_d1 (
        .clk(clk), .reset(reset),
        .asc_data_valid(asc_data_valid), .asc_data_ready(d1_ready), .asc_data_in(asc_data_in),
        .asc_response_valid(d1_rv), .asc_response_ready(asc_response_ready),
        .asc_response_data(d1_rdata), .scan_clk(d1_sclk), .scan_in(d1_sin),
        .scan_update(d1_upd), .busy(d1_busy), .debug_state(d1_state)
    );

    logic       cur_ready, cur_rv, cur_sclk, cur_sin, cur_upd, cur_busy;
    logic [7:0] cur_rdata;
    logic [2:0] cur_state;
    assign cur_ready = sel ? d1_ready : d2_ready;
    assign cur_rv    = sel ? d1_rv    : d2_rv;
    assign cur_sclk  = sel ? d1_sclk  : d2_sclk;
    assign cur_sin   = sel ? d1_sin   : d2_sin;
    assign cur_upd   = sel ? d1_upd   : d2_upd;
    assign cur_busy  = sel ? d1_busy  : d2_busy;
    assign cur_rdata = sel ? d1_rdata : d2_rdata;
    assign cur_state = sel ? d1_state : d2_state;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: scan bits on scan_clk rise, pulse/ack/handshake bookkeeping.
    int   cyc = 0;
    logic bits[$];
    logic prev_sclk = 1'b0, prev_upd = 1'b0, prev_rv = 1'b0;
    int   upd_pulses = 0, upd_run = 0, upd_len_last = 0, acks = 0, acc_cnt = 0;
    int   ready_bad = 0, t_acc = 0, t_upd = 0, t_resp = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cur_sclk && !prev_sclk) bits.push_back(cur_sin);
        if (cur_upd && !prev_upd) begin
            upd_pulses <= upd_pulses + 1;
            t_upd      <= cyc;
        end
        if (cur_upd) upd_run <= upd_run + 1;
        else begin
            if (prev_upd) upd_len_last <= upd_run;
            upd_run <= 0;
        end
        if (cur_rv && !prev_rv) t_resp <= cyc;
        if (cur_rv && asc_response_ready) acks <= acks + 1;
        if (cur_ready && asc_data_valid) begin
            acc_cnt <= acc_cnt + 1;
            t_acc   <= cyc;
        end
        if ((cur_ready !== (cur_state == 3'd0)) || (cur_busy === cur_ready)) ready_bad <= ready_bad + 1;
        prev_sclk <= cur_sclk;
        prev_upd  <= cur_upd;
        prev_rv   <= cur_rv;
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Present one byte; returns #1 after the edge that accepted it (valid left high).
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        asc_data_in    = b;
        asc_data_valid = 1'b1;
        @(negedge clk);
        while (!cur_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!cur_ready) begin
            tests++;
            fails++;
            $display("FAIL byte_accept_timeout: ready=%0b required 1", cur_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic send_packet(input logic [7:0] start, input logic [7:0] inc,
                               input logic toggle, input int gap);
        logic [7:0] b;
        b = start;
        for (int k = 0; k < 22; k++) begin
            if (toggle && k > 0) begin
                asc_data_valid = 1'b0;
                @(posedge clk); #1;
            end
            if (gap > 0 && k == 11) begin
                asc_data_valid = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
            send_byte(b);
            b = b + inc;
        end
        asc_data_valid = 1'b0;
    endtask

    task automatic wait_ack(input string name);
        int   n = 0;
        logic ok;
        @(negedge clk);
        while (!(cur_rv && asc_response_ready) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        ok = cur_rv && asc_response_ready;
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL %s ack_timeout: response_valid=%0b required 1", name, cur_rv);
        end else begin
            check({name, " ack_data"}, cur_rdata, 8'h01);
            @(posedge clk); #1;
            @(negedge clk);
            check({name, " ready_after_ack"}, cur_ready, 1);
            check({name, " state_after_ack"}, cur_state, 0);
        end
        @(posedge clk); #1;
    endtask

    task automatic check_bits(input string name, input int base, input logic [175:0] exp);
        int mism = 0;
        check({name, " bit_count"}, bits.size() - base, 176);
        for (int i = 0; i < 176; i++) begin
            if (base + i >= bits.size()) mism++;
            else if (bits[base + i] !== exp[i]) mism++;
        end
        check({name, " bit_mismatches"}, mism, 0);
    endtask

    typedef struct {
        logic         div1;
        logic [7:0]   start;
        logic [7:0]   inc;
        logic         toggle;
        int           gap;
        logic [175:0] exp_bits;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int nb, np, na, d, n;
        int bad_v, bad_d, bad_r, acc_snap;
        logic [175:0] exp_inc;
        exp_inc = 176'h1514131211100f0e0d0c0b0a09080706050403020100;

        vecs[0] = '{1'b0, 8'h00, 8'h01, 1'b0, 0,  exp_inc};
        vecs[1] = '{1'b0, 8'h00, 8'h01, 1'b1, 20, exp_inc};
        vecs[2] = '{1'b1, 8'hA5, 8'h00, 1'b0, 0,  {22{8'hA5}}};
        vecs[3] = '{1'b1, 8'h5A, 8'h00, 1'b0, 0,  {22{8'h5A}}};

        // Reset state.
        do_reset();
        @(negedge clk);
        check("rst scan_clk", cur_sclk, 0);
        check("rst scan_in", cur_sin, 0);
        check("rst scan_update", cur_upd, 0);
        check("rst resp_valid", cur_rv, 0);
        check("rst resp_data", cur_rdata, 0);
        check("rst data_ready", cur_ready, 1);
        check("rst busy", cur_busy, 0);
        check("rst debug_state", cur_state, 0);
        @(posedge clk); #1;

        // Table-driven packets.
        for (int i = 0; i < 4; i++) begin
            if (vecs[i].div1 != sel) begin
                sel = vecs[i].div1;
                do_reset();
            end
            d  = sel ? 1 : 2;
            nb = bits.size();
            np = upd_pulses;
            na = acks;
            send_packet(vecs[i].start, vecs[i].inc, vecs[i].toggle, vecs[i].gap);
            wait_ack($sformatf("vec%0d", i));
            check_bits($sformatf("vec%0d", i), nb, vecs[i].exp_bits);
            check($sformatf("vec%0d update_pulses", i), upd_pulses - np, 1);
            check($sformatf("vec%0d update_len", i), upd_len_last, 2 * d);
            check($sformatf("vec%0d update_latency", i), t_upd - t_acc, 1 + 2 * d * 176);
            check($sformatf("vec%0d resp_after_update", i), t_resp - t_upd, 2 * d);
            check($sformatf("vec%0d acks", i), acks - na, 1);
        end

        // Response back-pressure with a pending byte.
        sel = 1'b0;
        do_reset();
        asc_response_ready = 1'b0;
        na = acks;
        send_packet(8'h30, 8'h01, 1'b0, 0);
        asc_data_in    = 8'h77;
        asc_data_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!cur_rv && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("hold resp_valid_seen", cur_rv, 1);
        acc_snap = acc_cnt;
        bad_v = 0; bad_d = 0; bad_r = 0;
        for (int i = 0; i < 10; i++) begin
            if (cur_rv !== 1'b1) bad_v++;
            if (cur_rdata !== 8'h01) bad_d++;
            if (cur_ready !== 1'b0) bad_r++;
            @(negedge clk);
        end
        check("hold valid_drops", bad_v, 0);
        check("hold data_changes", bad_d, 0);
        check("hold ready_high", bad_r, 0);
        @(posedge clk); #1;
        check("hold byte_consumed", acc_cnt - acc_snap, 0);
        check("hold no_ack", acks - na, 0);
        asc_response_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("release state", cur_state, 0);
        check("release ready", cur_ready, 1);
        check("release resp_valid", cur_rv, 0);
        @(posedge clk); #1;
        asc_data_valid = 1'b0;
        check("release pending_taken", acc_cnt - acc_snap, 1);
        check("release acks", acks - na, 1);

        // Reset in the middle of shifting, then a fresh packet of ones.
        do_reset();
        nb = bits.size();
        send_packet(8'h00, 8'h01, 1'b0, 0);
        n = 0;
        while (bits.size() < nb + 50 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("midrst bits_before", bits.size() - nb >= 50, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst scan_clk", cur_sclk, 0);
        check("midrst scan_in", cur_sin, 0);
        check("midrst scan_update", cur_upd, 0);
        check("midrst resp_valid", cur_rv, 0);
        check("midrst data_ready", cur_ready, 1);
        @(posedge clk); #1;
        nb = bits.size();
        send_packet(8'hFF, 8'h00, 1'b0, 0);
        wait_ack("ones");
        check_bits("ones", nb, {176{1'b1}});

        check("ready_only_in_collect", ready_bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
